// File: rtl/mult_sched_pkg.sv
// Shared types and widths for the multiplier scheduler.
// No logic; imported by the interface, arbiter and top.
// No backpressure (constants only).
package mult_sched_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int OPW      = 4;
    localparam int PRW      = 8;
    localparam int NREQ_DEF = 4;
endpackage

// File: rtl/mult_sched_if.sv
// Requester-side bundle: request level, operands, grant/done pulses, product.
// Wires only, no latency.
// Requesters hold req until gnt; gnt/done are single-cycle pulses.
interface mult_sched_if import mult_sched_pkg::*; #(
    parameter int NREQ = NREQ_DEF
);
    logic [NREQ-1:0]     req;
    logic [OPW*NREQ-1:0] req_a;
    logic [OPW*NREQ-1:0] req_b;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [PRW-1:0]      p_out;

    modport master (output req, req_a, req_b, input gnt, done, p_out);
    modport slave  (input req, req_a, req_b, output gnt, done, p_out);
endinterface

// File: rtl/mult_sched_rr_pick.sv
// Winner select: round-robin from ptr, or lowest index if MULT_SCHED_FIXED_PRIO_EN.
// Purely combinational.
// No backpressure; any=0 when no request is pending.
module rr_pick #(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] oh,
    output logic [IW-1:0]   idx,
    output logic            any
);
    logic [IW-1:0] sel;

    always_comb begin
        oh  = '0;
        idx = '0;
        any = 1'b0;
        sel = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef MULT_SCHED_FIXED_PRIO_EN
            sel = IW'(k);
`else
            sel = IW'((int'(ptr) + k) % NREQ);
`endif
            if (!any && req[sel]) begin
                any     = 1'b1;
                oh[sel] = 1'b1;
                idx     = sel;
            end
        end
    end
endmodule

// File: rtl/mult_sched.sv
// Shares one sequential multiplier among NREQ requesters (MULT_SCHED_FIXED_PRIO_EN: fixed priority).
// Latency: gnt at T+1, done/product at T+2+MULT_LAT after req sampled in IDLE at T.
// Requests are sampled only in IDLE; a granted operation always completes.
module mult_sched import mult_sched_pkg::*; #(
    parameter int NREQ     = NREQ_DEF,
    parameter int MULT_LAT = 10
) (
    input  logic           clk,
    input  logic           resetn,
    mult_sched_if.slave    rq,
    output logic           busy,
    output logic           mult_start_n,
    output logic [OPW-1:0] mult_a,
    output logic [OPW-1:0] mult_b,
    input  logic [PRW-1:0] mult_p
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MULT_LAT + 1);

    state_t          state, state_nxt;
    logic [IW-1:0]   owner, rr_ptr, win_idx;
    logic [NREQ-1:0] owner_oh, win_oh;
    logic            win_any;
    logic [CW-1:0]   cnt;
    logic [PRW-1:0]  p_q;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req (rq.req),
        .ptr (rr_ptr),
        .oh  (win_oh),
        .idx (win_idx),
        .any (win_any)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        rq.gnt       = '0;
        rq.done      = '0;
        mult_start_n = 1'b1;
        busy         = (state != IDLE);
        case (state)
            IDLE:  if (win_any) state_nxt = ISSUE;
            ISSUE: begin
                rq.gnt       = owner_oh;
                mult_start_n = 1'b0;
                state_nxt    = WAIT;
            end
            WAIT:  if (cnt == '0) state_nxt = DONE;
            DONE: begin
                rq.done   = owner_oh;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rq.p_out = p_q;

    // Operands and owner are latched in IDLE so they stay stable through DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mult_a   <= '0;
            mult_b   <= '0;
            owner    <= '0;
            owner_oh <= '0;
            cnt      <= '0;
            p_q      <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: if (win_any) begin
                    mult_a   <= rq.req_a[win_idx*OPW +: OPW];
                    mult_b   <= rq.req_b[win_idx*OPW +: OPW];
                    owner    <= win_idx;
                    owner_oh <= win_oh;
                end
                ISSUE: cnt <= CW'(MULT_LAT - 1);
                WAIT: begin
                    if (cnt == '0) p_q <= mult_p;
                    else           cnt <= cnt - 1'b1;
                end
                DONE: begin
`ifndef MULT_SCHED_FIXED_PRIO_EN
                    rr_ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_sched.sv
// Scoreboarded bench for mult_sched with a behavioural multiplier (NREQ=4, MULT_LAT=10).
module tb_mult_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 10;

    logic       clk = 1'b0;
    logic       resetn;
    logic       busy, mult_start_n;
    logic [3:0] mult_a, mult_b;
    logic [7:0] mult_p, pend;
    int         left;

    typedef struct { int idx; int p; } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int A[4];
    int B[4];
    int last_p;

    mult_sched_if #(.NREQ(NREQ)) rq();

    mult_sched #(.NREQ(NREQ), .MULT_LAT(LAT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rq           (rq),
        .busy         (busy),
        .mult_start_n (mult_start_n),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_p       (mult_p)
    );

    always #5 clk = ~clk;

    // Product is garbage until LAT cycles after the start cycle.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mult_p <= 8'h00;
            pend   <= 8'h00;
            left   <= 0;
        end else if (!mult_start_n) begin
            pend   <= {4'b0, mult_a} * {4'b0, mult_b};
            mult_p <= 8'hA5;
            left   <= LAT - 1;
        end else if (left > 0) begin
            left <= left - 1;
            if (left == 1) mult_p <= pend;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic apply_ops();
        for (int i = 0; i < 4; i++) begin
            rq.req_a[4*i +: 4] = A[i][3:0];
            rq.req_b[4*i +: 4] = B[i][3:0];
        end
    endtask

    task automatic sb_push(input int idx);
        exp_t e;
        e.idx = idx;
        e.p   = A[idx] * B[idx];
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rq.done != 4'b0) begin
            if (sb.size() == 0) chk("done_unexpected", int'(rq.done), 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_owner", int'(rq.done), 1 << e.idx);
                chk("p_out", int'(rq.p_out), e.p);
            end
        end
    end

    task automatic check_reset_vals();
        chk("rst_gnt", int'(rq.gnt), 0);
        chk("rst_done", int'(rq.done), 0);
        chk("rst_p_out", int'(rq.p_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_start_n", int'(mult_start_n), 1);
        chk("rst_mult_a", int'(mult_a), 0);
        chk("rst_mult_b", int'(mult_b), 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        last_p = 0;
    endtask

    task automatic wait_idle();
        int c;
        for (c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (c == 20) chk("idle_timeout", c, 0);
    endtask

    // Cycle-exact single operation; caller is at a negedge with the DUT idle.
    task automatic single(input int idx, input int a, input int b, input int drop_at);
        A[idx] = a;
        B[idx] = b;
        apply_ops();
        sb_push(idx);
        rq.req = 4'(1 << idx);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == drop_at) rq.req[idx] = 1'b0;
            chk("gnt", int'(rq.gnt), (k == 1) ? (1 << idx) : 0);
            chk("start_n", int'(mult_start_n), (k == 1) ? 0 : 1);
            chk("busy", int'(busy), (k <= 12) ? 1 : 0);
            chk("done", int'(rq.done), (k == 12) ? (1 << idx) : 0);
            if (k < 12) chk("p_hold", int'(rq.p_out), last_p);
            if (k <= 12) begin
                chk("mult_a", int'(mult_a), a);
                chk("mult_b", int'(mult_b), b);
            end
        end
        last_p = a * b;
    endtask

    task automatic serve(input logic [3:0] r, input int n, input int ex[5], input bit hold);
        int k = 0;
        for (int i = 0; i < n; i++) sb_push(ex[i]);
        rq.req = r;
        for (int c = 0; c < n * 14 + 5 && k < n; c++) begin
            @(negedge clk);
            if (rq.gnt != 4'b0) begin
                chk("gnt_onehot", $countones(rq.gnt), 1);
                chk("gnt_order", oh2idx(rq.gnt), ex[k]);
                if (!hold) rq.req = rq.req & ~rq.gnt;
                k++;
                if (k == n) rq.req = 4'b0;
            end
        end
        if (k < n) chk("gnt_timeout", k, n);
        wait_idle();
        last_p = A[ex[n-1]] * B[ex[n-1]];
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        resetn   = 1'b0;
        rq.req   = 4'b0;
        rq.req_a = '0;
        rq.req_b = '0;
        for (int i = 0; i < 4; i++) begin A[i] = 0; B[i] = 0; end
        last_p = 0;
        repeat (2) @(negedge clk);
        check_reset_vals();
        resetn = 1'b1;
        @(negedge clk);
        check_reset_vals();

        single(0, 3, 5, 1);

        do_reset();
        for (int i = 0; i < 4; i++) begin A[i] = i + 2; B[i] = i + 3; end
        apply_ops();
`ifdef MULT_SCHED_FIXED_PRIO_EN
        serve(4'b1111, 3, '{0, 0, 0, 0, 0}, 1'b1);
`else
        serve(4'b1111, 5, '{0, 1, 2, 3, 0}, 1'b1);
`endif

        sb_push(2);
        rq.req = 4'b0100;
        @(negedge clk);
        chk("rot_first", oh2idx(rq.gnt), 2);
        rq.req = 4'b0000;
        repeat (3) @(negedge clk);
        serve(4'b0110, 2, '{1, 2, 0, 0, 0}, 1'b0);

        single(0, 15, 15, 1);
        repeat (5) begin
            @(negedge clk);
            chk("p_idle_hold", int'(rq.p_out), 225);
        end
        single(1, 0, 9, 1);

        single(3, 9, 7, 2);

        A[2] = 5;
        B[2] = 5;
        apply_ops();
        rq.req = 4'b0100;
        @(negedge clk);
        rq.req = 4'b0000;
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        check_reset_vals();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        last_p = 0;
        ndone = 0;
        repeat (16) begin
            @(negedge clk);
            if (rq.done != 4'b0) ndone++;
        end
        chk("no_done_after_rst", ndone, 0);
        chk("idle_after_rst", int'(busy), 0);
        single(1, 7, 6, 1);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
